clk_div_bank: RTL and testbench

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_pkg.sv | 9 +
 rtl/clk_div_channel.sv | 69 ++++++
 rtl/clk_div_bank.sv | 79 +++++++
 tb/tb_clk_div_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared defaults and divisor type for the clock-divider bank.
package clk_pkg;

  localparam int unsigned DIV_W_DEF    = 16;
  localparam int unsigned DIV_INIT_DEF = 100;

  typedef logic [DIV_W_DEF-1:0] div_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: wrap counter, shadowed divisor and 50%-duty toggle output.
module clk_div_channel
  import clk_pkg::*;
#(
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             run_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_val_i,
  output logic             clk_en_o,
  output logic             clk_o,
  output logic             pending_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             en_q, en_d;
  logic             clk_q, clk_d;

  logic [DIV_W-1:0] deff, deff_next;
  logic             wrap, apply;

  always_comb begin
    deff     = (div_q == '0) ? DIV_W'(1) : div_q;
    wrap     = run_i && (cnt_q >= deff - DIV_W'(1));
    cnt_d    = '0;
    if (run_i && !wrap) cnt_d = cnt_q + DIV_W'(1);

    // Staged value moves over only at a period boundary or while idle;
    // a write landing on that same edge stays staged for the next one.
    apply    = pend_q && (wrap || !run_i);
    div_d    = apply ? shadow_q : div_q;
    shadow_d = wr_i ? wr_val_i : shadow_q;
    pend_d   = wr_i ? 1'b1 : (apply ? 1'b0 : pend_q);

    // Enable is registered, so look ahead at the post-edge count and divisor.
    deff_next = (div_d == '0) ? DIV_W'(1) : div_d;
    en_d      = run_i && (cnt_d == deff_next - DIV_W'(1));
    clk_d     = run_i ? (clk_q ^ en_q) : 1'b0;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q    <= '0;
      div_q    <= DIV_W'(DIV_INIT);
      shadow_q <= DIV_W'(DIV_INIT);
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      clk_q    <= clk_d;
    end
  end

  assign clk_en_o  = en_q;
  assign clk_o     = clk_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable clock-enable dividers gated by a lock-sequenced system reset.
module clk_div_bank
  import clk_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DIV_INIT = DIV_INIT_DEF,
  parameter int unsigned RST_HOLD = 16,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              locked_i,
  input  logic              div_wr_i,
  input  logic [CH_W-1:0]   div_ch_i,
  input  logic [DIV_W-1:0]  div_val_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic              sys_resetn_o
);

  localparam int unsigned HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              sysrst_q, sysrst_d;

  always_comb begin
    sync1_d  = locked_i;
    sync2_d  = sync1_q;
    hold_d   = '0;
    sysrst_d = 1'b0;
    if (sync2_q) begin
      if (hold_q != HOLD_W'(RST_HOLD)) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d   = hold_q;
        sysrst_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hold_q   <= '0;
      sysrst_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      hold_q   <= hold_d;
      sysrst_q <= sysrst_d;
    end
  end

  assign sys_resetn_o = sysrst_q;

  // Out-of-range channel selects match no generate index and are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .DIV_W   (DIV_W),
      .DIV_INIT(DIV_INIT)
    ) u_ch (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .run_i    (sysrst_q & ch_en_i[g]),
      .wr_i     (div_wr_i && (div_ch_i == CH_W'(g))),
      .wr_val_i (div_val_i),
      .clk_en_o (clk_en_o[g]),
      .clk_o    (clk_o[g]),
      .pending_o(pending_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank.
module tb_clk_div_bank;

  localparam int unsigned NUM_CH   = 6;
  localparam int unsigned DIV_W    = 16;
  localparam int unsigned DIV_INIT = 20;
  localparam int unsigned RST_HOLD = 16;
  localparam int unsigned CH_W     = 3;

  logic              clk_i = 1'b0;
  logic              resetn_i;
  logic              locked_i;
  logic              div_wr_i;
  logic [CH_W-1:0]   div_ch_i;
  logic [DIV_W-1:0]  div_val_i;
  logic [NUM_CH-1:0] ch_en_i;
  logic [NUM_CH-1:0] clk_en_o;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] pending_o;
  logic              sys_resetn_o;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .DIV_INIT(DIV_INIT),
    .RST_HOLD(RST_HOLD)
  ) dut (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .locked_i    (locked_i),
    .div_wr_i    (div_wr_i),
    .div_ch_i    (div_ch_i),
    .div_val_i   (div_val_i),
    .ch_en_i     (ch_en_i),
    .clk_en_o    (clk_en_o),
    .clk_o       (clk_o),
    .pending_o   (pending_o),
    .sys_resetn_o(sys_resetn_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] val);
    div_wr_i  = 1'b1;
    div_ch_i  = ch;
    div_val_i = val;
    tick(1);
    div_wr_i  = 1'b0;
  endtask

  initial begin
    resetn_i = 1'b0; locked_i = 1'b0; div_wr_i = 1'b0;
    div_ch_i = '0; div_val_i = '0; ch_en_i = '0;
    tick(3);
    check("rst_sys", 32'(sys_resetn_o), 0);
    check("rst_en", 32'(clk_en_o), 0);
    check("rst_clk", 32'(clk_o), 0);
    check("rst_pend", 32'(pending_o), 0);

    resetn_i = 1'b1;
    tick(3);
    check("no_lock_sys", 32'(sys_resetn_o), 0);

    // lock: 2 sync + 16 hold, release on the 19th edge
    locked_i = 1'b1;
    tick(18);
    check("lock_hold", 32'(sys_resetn_o), 0);
    tick(1);
    check("lock_rel", 32'(sys_resetn_o), 1);

    // ch0 D=4 programmed while idle
    wr(0, 4);
    check("d4_pend_set", 32'(pending_o[0]), 1);
    tick(1);
    check("d4_pend_clr", 32'(pending_o[0]), 0);
    ch_en_i[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      check($sformatf("d4_en_k%0d", k), 32'(clk_en_o[0]), 32'((k % 4) == 3));
      check($sformatf("d4_clk_k%0d", k), 32'(clk_o[0]), 32'((k / 4) % 2));
    end

    ch_en_i[0] = 1'b0;
    tick(1);
    check("dis_en", 32'(clk_en_o[0]), 0);
    check("dis_clk", 32'(clk_o[0]), 0);

    // D=10, then write 3 while cnt=2
    wr(0, 10);
    tick(1);
    check("d10_applied", 32'(pending_o[0]), 0);
    ch_en_i[0] = 1'b1;
    tick(2);
    wr(0, 3);
    check("d3_pend_a", 32'(pending_o[0]), 1);
    tick(6);
    check("d3_pend_b", 32'(pending_o[0]), 1);
    check("d10_last_en", 32'(clk_en_o[0]), 1);
    tick(1);
    check("d3_pend_clr", 32'(pending_o[0]), 0);
    check("d3_wrap_en", 32'(clk_en_o[0]), 0);
    tick(2);
    check("d3_en_a", 32'(clk_en_o[0]), 1);
    tick(3);
    check("d3_en_b", 32'(clk_en_o[0]), 1);

    // 5 on the wrap edge, then 7: last write wins at the following wrap
    wr(0, 5);
    check("w5_pend", 32'(pending_o[0]), 1);
    check("w5_en", 32'(clk_en_o[0]), 0);
    wr(0, 7);
    check("w7_pend", 32'(pending_o[0]), 1);
    tick(1);
    check("w7_old_period", 32'(clk_en_o[0]), 1);
    check("w7_pend_hold", 32'(pending_o[0]), 1);
    tick(1);
    check("w7_pend_clr", 32'(pending_o[0]), 0);
    tick(5);
    check("d7_en_lo", 32'(clk_en_o[0]), 0);
    tick(1);
    check("d7_en_hi", 32'(clk_en_o[0]), 1);

    // D=0 behaves as D=1
    ch_en_i[0] = 1'b0;
    wr(0, 0);
    check("d0_pend", 32'(pending_o[0]), 1);
    check("d0_dis_en", 32'(clk_en_o[0]), 0);
    check("d0_dis_clk", 32'(clk_o[0]), 0);
    tick(1);
    check("d0_pend_clr", 32'(pending_o[0]), 0);
    ch_en_i[0] = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick(1);
      check($sformatf("d0_en_j%0d", j), 32'(clk_en_o[0]), 1);
      check($sformatf("d0_clk_j%0d", j), 32'(clk_o[0]), 32'((j - 1) % 2));
    end

    // ch1 D=6, drop and re-enable mid-count
    wr(1, 6);
    tick(1);
    ch_en_i[1] = 1'b1;
    tick(8);
    check("c1_clk_hi", 32'(clk_o[1]), 1);
    check("c1_en_lo", 32'(clk_en_o[1]), 0);
    ch_en_i[1] = 1'b0;
    tick(1);
    check("c1_drop_en", 32'(clk_en_o[1]), 0);
    check("c1_drop_clk", 32'(clk_o[1]), 0);
    ch_en_i[1] = 1'b1;
    tick(4);
    check("c1_re_en_lo", 32'(clk_en_o[1]), 0);
    tick(1);
    check("c1_re_en_hi", 32'(clk_en_o[1]), 1);

    wr(7, 2);
    check("bad_ch_pend", 32'(pending_o), 0);
    tick(5);
    check("bad_ch_c1_period", 32'(clk_en_o[1]), 1);

    // lock loss
    locked_i = 1'b0;
    tick(2);
    check("unlock_sys_a", 32'(sys_resetn_o), 1);
    tick(1);
    check("unlock_sys_b", 32'(sys_resetn_o), 0);
    tick(1);
    check("unlock_clk", 32'(clk_o), 0);
    check("unlock_en", 32'(clk_en_o), 0);

    // relock, then async reset mid-period
    locked_i = 1'b1;
    tick(25);
    check("relock_sys", 32'(sys_resetn_o), 1);
    #3;
    resetn_i = 1'b0;
    #1;
    check("async_sys", 32'(sys_resetn_o), 0);
    check("async_en", 32'(clk_en_o), 0);
    check("async_clk", 32'(clk_o), 0);
    check("async_pend", 32'(pending_o), 0);
    tick(1);
    resetn_i = 1'b1;
    tick(37);
    check("init_div_lo", 32'(clk_en_o[1:0]), 0);
    tick(1);
    check("init_div_hi", 32'(clk_en_o[1:0]), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
